fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_ctrl_pkg.sv | 10 +
 rtl/fifo_ctrl_mem_ctr.sv | 82 ++++++++
 rtl/fifo_ctrl.sv | 114 +++++++++++
 tb/tb_fifo_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and defaults for the two-bank FIFO controller.
package fifo_ctrl_pkg;
  localparam int AW_DEF = 3;
  localparam int DW_DEF = 32;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;
endpackage

// File: rtl/fifo_ctrl_mem_ctr.sv
// Steers FIFO reads/writes onto two single-port banks (address bit 0 picks the bank).
// A write colliding with a read on the same bank is deferred by one cycle.
module mem_ctr
  import fifo_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd,
  input  logic          wr,
  input  logic [AW-1:0] r_adr,
  input  logic [AW-1:0] w_adr,
  input  logic [DW-1:0] di,
  output logic          ENABLE_0,
  output logic          WE_0,
  output logic [AW-2:0] A_0,
  output logic [DW-1:0] DI_0,
  output logic          ENABLE_1,
  output logic          WE_1,
  output logic [AW-2:0] A_1,
  output logic [DW-1:0] DI_1,
  output logic          pend_v,
  output logic [AW-1:0] pend_adr
);
  logic [DW-1:0]          pend_data;
  logic                   conflict;
  logic [1:0]             en, we;
  logic [1:0][AW-2:0]     a;
  logic [1:0][DW-1:0]     d;

  // Both pointers advance after a collision, so next cycle's requests hit the
  // other bank and never clash with the deferred write.
  always_comb begin
    en = '0;
    we = '0;
    a  = '0;
    d  = '0;
    conflict = rd & wr & (r_adr[0] == w_adr[0]);
    if (pend_v) begin
      en[pend_adr[0]] = 1'b1;
      we[pend_adr[0]] = 1'b1;
      a[pend_adr[0]]  = pend_adr[AW-1:1];
      d[pend_adr[0]]  = pend_data;
    end
    if (rd) begin
      en[r_adr[0]] = 1'b1;
      we[r_adr[0]] = 1'b0;
      a[r_adr[0]]  = r_adr[AW-1:1];
    end
    if (wr && !conflict) begin
      en[w_adr[0]] = 1'b1;
      we[w_adr[0]] = 1'b1;
      a[w_adr[0]]  = w_adr[AW-1:1];
      d[w_adr[0]]  = di;
    end
  end

  assign ENABLE_0 = en[0];
  assign WE_0     = we[0];
  assign A_0      = a[0];
  assign DI_0     = d[0];
  assign ENABLE_1 = en[1];
  assign WE_1     = we[1];
  assign A_1      = a[1];
  assign DI_1     = d[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v    <= 1'b0;
      pend_adr  <= '0;
      pend_data <= '0;
    end else begin
      pend_v <= conflict;
      if (conflict) begin
        pend_adr  <= w_adr;
        pend_data <= di;
      end
    end
  end
endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller over two SPRAM banks with flush FSM.
// Define FIFO_CTRL_ERR_EN to add sticky ovf/udf error flags.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          push_ready,
  input  logic          pop,
  output logic          pop_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          flush,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
`ifdef FIFO_CTRL_ERR_EN
  output logic          ovf,
  output logic          udf,
`endif
  output logic          ENABLE_0,
  output logic          WE_0,
  output logic [AW-2:0] A_0,
  output logic [DW-1:0] DI_0,
  output logic          ENABLE_1,
  output logic          WE_1,
  output logic [AW-2:0] A_1,
  output logic [DW-1:0] DI_1,
  input  logic [DW-1:0] DO_0,
  input  logic [DW-1:0] DO_1
);
  localparam logic [AW:0] WRAP_ONLY = {1'b1, {AW{1'b0}}};

  state_t        state, state_nx;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          rd_bank;
  logic          pend_v, pend_hit, run;
  logic [AW-1:0] pend_adr;
  logic          push_acc, pop_acc;

  assign run        = (state == RUN);
  assign full       = ((wr_ptr ^ rd_ptr) == WRAP_ONLY);
  assign empty      = (wr_ptr == rd_ptr);
  assign count      = wr_ptr - rd_ptr;
  assign pend_hit   = pend_v & (rd_ptr[AW-1:0] == pend_adr);
  assign push_ready = ~full & run;
  assign pop_ready  = ~empty & run & ~pend_hit;
  assign push_acc   = push & push_ready & ~flush;
  assign pop_acc    = pop & pop_ready & ~flush;
  assign rd_data    = rd_bank ? DO_1 : DO_0;

  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (flush) state_nx = FLUSH;
      FLUSH:   if (!pend_v) state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_bank  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_valid <= pop_acc;
      if (pop_acc) rd_bank <= rd_ptr[0];
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (!run || flush) rd_ptr <= wr_ptr;
      else if (pop_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (run) begin
      if (push && full) ovf <= 1'b1;
      if (pop && empty) udf <= 1'b1;
    end
  end
`endif

  mem_ctr #(.AW(AW), .DW(DW)) u_mem (
    .clk      (clk),
    .rst      (rst),
    .rd       (pop_acc),
    .wr       (push_acc),
    .r_adr    (rd_ptr[AW-1:0]),
    .w_adr    (wr_ptr[AW-1:0]),
    .di       (push_data),
    .ENABLE_0 (ENABLE_0),
    .WE_0     (WE_0),
    .A_0      (A_0),
    .DI_0     (DI_0),
    .ENABLE_1 (ENABLE_1),
    .WE_1     (WE_1),
    .A_1      (A_1),
    .DI_1     (DI_1),
    .pend_v   (pend_v),
    .pend_adr (pend_adr)
  );
endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with two behavioural SPRAM banks.
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;
  localparam int AW = 3;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, push, pop, flush;
  logic [DW-1:0] push_data;
  logic          push_ready, pop_ready, rd_valid, full, empty;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic          ENABLE_0, WE_0, ENABLE_1, WE_1;
  logic [AW-2:0] A_0, A_1;
  logic [DW-1:0] DI_0, DI_1, DO_0, DO_1;
`ifdef FIFO_CTRL_ERR_EN
  logic          ovf, udf;
`endif
  int checks = 0;
  int errors = 0;

  fifo_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .push_ready(push_ready),
    .pop(pop), .pop_ready(pop_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .flush(flush), .count(count), .full(full), .empty(empty),
`ifdef FIFO_CTRL_ERR_EN
    .ovf(ovf), .udf(udf),
`endif
    .ENABLE_0(ENABLE_0), .WE_0(WE_0), .A_0(A_0), .DI_0(DI_0),
    .ENABLE_1(ENABLE_1), .WE_1(WE_1), .A_1(A_1), .DI_1(DI_1),
    .DO_0(DO_0), .DO_1(DO_1)
  );

  always #5 clk = ~clk;

  // Registered-read single-port banks
  logic [DW-1:0] m0 [0:3];
  logic [DW-1:0] m1 [0:3];
  always @(posedge clk) begin
    if (ENABLE_0) begin
      if (WE_0) m0[A_0] <= DI_0;
      else      DO_0    <= m0[A_0];
    end
    if (ENABLE_1) begin
      if (WE_1) m1[A_1] <= DI_1;
      else      DO_1    <= m1[A_1];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, sample 1ns after the edge
  task automatic cyc(input logic p, input logic [DW-1:0] d, input logic o, input logic f);
    push = p; push_data = d; pop = o; flush = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; push_data = '0;
    DO_0 = '0; DO_1 = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // reset state
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_push_ready", push_ready, 1);
    chk("rst_pop_ready", pop_ready, 0);
    chk("rst_en", {ENABLE_0, WE_0, ENABLE_1, WE_1}, 0);
    chk("rst_rd_valid", rd_valid, 0);

    // fill to full
    for (int i = 0; i < 8; i++) begin
      cyc(1, 32'hA0 + i, 0, 0);
      chk("fill_count", count, i + 1);
    end
    chk("fill_full", full, 1);
    chk("fill_push_ready", push_ready, 0);
    cyc(1, 32'hFF, 0, 0);
    chk("ovf_push_count", count, 8);
    chk("ovf_push_full", full, 1);

    // drain in order
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 0);
      chk("drain_valid", rd_valid, 1);
      chk("drain_data", rd_data, 32'hA0 + i);
    end
    cyc(0, 0, 0, 0);
    chk("drain_valid_off", rd_valid, 0);
    chk("drain_empty", empty, 1);
    chk("drain_pop_ready", pop_ready, 0);

    // same-bank push+pop deferral at rd_ptr=2, wr_ptr=4
    rst = 1'b1; cyc(0, 0, 0, 0); rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1, 32'hB0 + i, 0, 0);
    cyc(0, 0, 1, 0); chk("def_pre0", rd_data, 32'hB0);
    cyc(0, 0, 1, 0); chk("def_pre1", rd_data, 32'hB1);
    chk("def_count_pre", count, 2);
    cyc(1, 32'hC0, 1, 0);
    chk("def_pend_v", dut.pend_v, 1);
    chk("def_count", count, 2);
    chk("def_rd", rd_data, 32'hB2);
    cyc(0, 0, 0, 0);
    chk("def_pend_clr", dut.pend_v, 0);
    chk("def_count2", count, 2);
    cyc(0, 0, 1, 0); chk("def_rd_b3", rd_data, 32'hB3);
    cyc(0, 0, 1, 0); chk("def_rd_c0", rd_data, 32'hC0);
    chk("def_empty", empty, 1);

    // 20 push/pop pairs, pointers wrap, colliding on every cycle
    cyc(1, 32'h100, 0, 0);
    cyc(1, 32'h101, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 32'h102 + i, 1, 0);
      chk("wrap_valid", rd_valid, 1);
      chk("wrap_data", rd_data, 32'h100 + i);
      chk("wrap_count", count, 2);
    end
    cyc(0, 0, 1, 0); chk("wrap_tail0", rd_data, 32'h114);
    cyc(0, 0, 1, 0); chk("wrap_tail1", rd_data, 32'h115);
    cyc(0, 0, 0, 0);
    chk("wrap_empty", empty, 1);
    chk("wrap_wr_ptr", dut.wr_ptr, 5'd11);

    // flush with a deferred write outstanding
    for (int i = 0; i < 6; i++) cyc(1, 32'h200 + i, 0, 0);
    cyc(1, 32'h206, 1, 0);
    chk("fl_pend_v", dut.pend_v, 1);
    chk("fl_count_pre", count, 6);
    chk("fl_rd", rd_data, 32'h200);
    cyc(1, 32'h2FF, 1, 1);
    chk("fl_state", dut.state, FLUSH);
    chk("fl_pend_done", dut.pend_v, 0);
    chk("fl_rd_valid", rd_valid, 0);
    chk("fl_push_ready", push_ready, 0);
    chk("fl_count", count, 0);
    cyc(0, 0, 0, 0);
    chk("fl_state_run", dut.state, RUN);
    chk("fl_empty", empty, 1);
    chk("fl_push_ready_run", push_ready, 1);

    // pop while empty is dropped
    cyc(0, 0, 1, 0);
    chk("udf_count", count, 0);
    chk("udf_rd_valid", rd_valid, 0);
`ifdef FIFO_CTRL_ERR_EN
    chk("udf_flag", udf, 1);
`endif
    for (int i = 0; i < 8; i++) cyc(1, 32'h300 + i, 0, 0);
    cyc(1, 32'h3FF, 0, 0);
    chk("full_again_count", count, 8);
`ifdef FIFO_CTRL_ERR_EN
    chk("ovf_set", ovf, 1);
    cyc(0, 0, 0, 0);
    chk("ovf_sticky", ovf, 1);
    cyc(0, 0, 0, 1);
    chk("ovf_clr", ovf, 0);
    chk("udf_clr", udf, 0);
`else
    cyc(0, 0, 0, 1);
`endif
    cyc(0, 0, 0, 0);
    chk("flush2_empty", empty, 1);

    // reset wins over everything with a write pending
    cyc(1, 32'h400, 0, 0);
    cyc(1, 32'h401, 0, 0);
    cyc(1, 32'h402, 1, 0);
    chk("rp_pend_v", dut.pend_v, 1);
    rst = 1'b1;
    cyc(1, 32'h403, 1, 1);
    rst = 1'b0;
    chk("rp_count", count, 0);
    chk("rp_pend_v_clr", dut.pend_v, 0);
    chk("rp_state", dut.state, RUN);
    chk("rp_rd_valid", rd_valid, 0);
    chk("rp_push_ready", push_ready, 1);
    cyc(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
